// File: rtl/u409_seq_pkg.sv
// u409_seq_pkg
// Shared types and constants for the U409 target sequencer.
//   state_e   : sequencer FSM states
//   target_e  : which engine owns the current bus cycle
//   Z2_AC_WINDOW / Z3_AC_WINDOW : default A[31:16] of the AUTOCONFIG windows
//   CNT_W     : watchdog counter width
//   decode_target() : address decode with fixed priority AC > BRIDGE > LIDE > PRO
package u409_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DECODE   = 3'd1,
    WAIT_ACK = 3'd2,
    TERM     = 3'd3,
    ERR      = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    AC     = 3'd1,
    BRIDGE = 3'd2,
    LIDE   = 3'd3,
    PRO    = 3'd4
  } target_e;

  localparam logic [15:0] Z2_AC_WINDOW = 16'h00E8;
  localparam logic [15:0] Z3_AC_WINDOW = 16'hFF00;
  localparam int          CNT_W        = 8;

  // a is A[31:16]; a[15:8] = A[31:24], a[12] = A28.
  function automatic target_e decode_target(
    input logic [15:0] a,
    input logic        configured,
    input logic        bridge_valid,
    input logic        lide_valid,
    input logic        pro_valid,
    input logic [7:0]  bridge_base,
    input logic [6:0]  lide_base,
    input logic [2:0]  pro_base,
    input logic [15:0] z2_base,
    input logic [15:0] z3_base
  );
    target_e t;
    t = NONE;
    if (!configured && (a == z2_base || a == z3_base))
      t = AC;
    else if (bridge_valid && a[15:8] == 8'h00 && a[7:0] == bridge_base)
      t = BRIDGE;
    else if (lide_valid && a[15:8] == 8'h00 && a[7:1] == lide_base)
      t = LIDE;
    else if (pro_valid && a[15:13] == pro_base && !a[12])
      t = PRO;
    return t;
  endfunction

endpackage

// File: rtl/u409_bus_watchdog.sv
// u409_bus_watchdog
// Saturating cycle counter for the WAIT_ACK watchdog.
//   clk, rst_n : clock, async active-low reset
//   clr        : reload counter to 0 (start of a new wait)
//   en         : count one wait cycle
//   expired    : the current wait cycle is the LIMIT-th one
module u409_bus_watchdog
  import u409_seq_pkg::*;
#(
  parameter int unsigned LIMIT = 255
)(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && cnt_q != MAX)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // cnt_q counts completed wait cycles, so LAST flags the LIMIT-th one.
  assign expired = (cnt_q >= LAST);

endmodule

// File: rtl/u409_target_sequencer.sv
// u409_target_sequencer
// Sequences each 68040 bus cycle owned by U409: latch on TSn, decode,
// raise one target select, wait for that target's ack, then emit a
// one-cycle TACK_OUT (or TEA_OUT on watchdog expiry).
// Inputs : CLK40, RESETn, TSn, RnW, A[31:16], CONFIGURED, *_VALID, *_BASE,
//          AC_TACK, BRIDGE_ACK, LIDE_ACK, PRO_ACK
// Outputs: AUTOCONFIG_SPACE, SEL_BRIDGE/LIDE/PRO, CYC_RnW, CYC_ACTIVE,
//          TACK_OUT, TEA_OUT (all registered)
// Build option: U409_BUS_TIMEOUT_EN enables the watchdog and ERR path;
// without it WAIT_ACK waits forever and TEA_OUT is 0.
module u409_target_sequencer
  import u409_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [15:0] Z2_AC_BASE     = Z2_AC_WINDOW,
  parameter logic [15:0] Z3_AC_BASE     = Z3_AC_WINDOW
)(
  input  logic        CLK40,
  input  logic        RESETn,
  input  logic        TSn,
  input  logic        RnW,
  input  logic [15:0] A,
  input  logic        CONFIGURED,
  input  logic        BRIDGE_VALID,
  input  logic        LIDE_VALID,
  input  logic        PRO_VALID,
  input  logic [7:0]  BRIDGE_BASE,
  input  logic [6:0]  LIDE_BASE,
  input  logic [2:0]  PRO_BASE,
  input  logic        AC_TACK,
  input  logic        BRIDGE_ACK,
  input  logic        LIDE_ACK,
  input  logic        PRO_ACK,
  output logic        AUTOCONFIG_SPACE,
  output logic        SEL_BRIDGE,
  output logic        SEL_LIDE,
  output logic        SEL_PRO,
  output logic        CYC_RnW,
  output logic        CYC_ACTIVE,
  output logic        TACK_OUT,
  output logic        TEA_OUT
);

  state_e  state_q, state_d;
  target_e tgt_q, tgt_d;
  logic    rnw_q, rnw_d;
  logic    ac_q, ac_d;
  logic    sel_b_q, sel_b_d;
  logic    sel_l_q, sel_l_d;
  logic    sel_p_q, sel_p_d;
  logic    act_q, act_d;
  logic    tack_q, tack_d;
  logic    tea_q, tea_d;
  logic    wd_clr, wd_en, timeout;
  logic    ack_sel;

  // Only the owning target's ack counts.
  always_comb begin
    unique case (tgt_q)
      AC:      ack_sel = AC_TACK;
      BRIDGE:  ack_sel = BRIDGE_ACK;
      LIDE:    ack_sel = LIDE_ACK;
      PRO:     ack_sel = PRO_ACK;
      default: ack_sel = 1'b0;
    endcase
  end

`ifdef U409_BUS_TIMEOUT_EN
  u409_bus_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk     (CLK40),
    .rst_n   (RESETn),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    rnw_d   = rnw_q;
    ac_d    = ac_q;
    sel_b_d = sel_b_q;
    sel_l_d = sel_l_q;
    sel_p_d = sel_p_q;
    act_d   = act_q;
    tack_d  = 1'b0;
    tea_d   = 1'b0;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    unique case (state_q)
      IDLE: if (!TSn) begin
        // Decode is resolved against the inputs present at TSn, so later
        // changes to CONFIGURED or the bases cannot disturb this cycle.
        tgt_d   = decode_target(A, CONFIGURED, BRIDGE_VALID, LIDE_VALID,
                                PRO_VALID, BRIDGE_BASE, LIDE_BASE, PRO_BASE,
                                Z2_AC_BASE, Z3_AC_BASE);
        rnw_d   = RnW;
        state_d = DECODE;
      end
      DECODE: begin
        if (tgt_q != NONE) begin
          ac_d    = (tgt_q == AC);
          sel_b_d = (tgt_q == BRIDGE);
          sel_l_d = (tgt_q == LIDE);
          sel_p_d = (tgt_q == PRO);
          act_d   = 1'b1;
          wd_clr  = 1'b1;
          state_d = WAIT_ACK;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_ACK: begin
        if (ack_sel)      state_d = TERM;
        else if (timeout) state_d = ERR;
        else              wd_en   = 1'b1;
      end
      TERM, ERR: begin
        tack_d  = (state_q == TERM);
        tea_d   = (state_q == ERR);
        ac_d    = 1'b0;
        sel_b_d = 1'b0;
        sel_l_d = 1'b0;
        sel_p_d = 1'b0;
        act_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      tgt_q   <= NONE;
      rnw_q   <= 1'b0;
      ac_q    <= 1'b0;
      sel_b_q <= 1'b0;
      sel_l_q <= 1'b0;
      sel_p_q <= 1'b0;
      act_q   <= 1'b0;
      tack_q  <= 1'b0;
      tea_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      rnw_q   <= rnw_d;
      ac_q    <= ac_d;
      sel_b_q <= sel_b_d;
      sel_l_q <= sel_l_d;
      sel_p_q <= sel_p_d;
      act_q   <= act_d;
      tack_q  <= tack_d;
      tea_q   <= tea_d;
    end
  end

  assign AUTOCONFIG_SPACE = ac_q;
  assign SEL_BRIDGE       = sel_b_q;
  assign SEL_LIDE         = sel_l_q;
  assign SEL_PRO          = sel_p_q;
  assign CYC_RnW          = rnw_q;
  assign CYC_ACTIVE       = act_q;
  assign TACK_OUT         = tack_q;
`ifdef U409_BUS_TIMEOUT_EN
  assign TEA_OUT          = tea_q;
`else
  assign TEA_OUT          = 1'b0;
`endif

endmodule

// File: tb/tb_u409_target_sequencer.sv
// Directed bench for u409_target_sequencer (TIMEOUT_CYCLES = 8).
// outs = {AUTOCONFIG_SPACE, SEL_BRIDGE, SEL_LIDE, SEL_PRO, CYC_ACTIVE, TACK_OUT, TEA_OUT}
module tb_u409_target_sequencer;

  logic        CLK40 = 1'b0;
  logic        RESETn = 1'b1;
  logic        TSn = 1'b1, RnW = 1'b0;
  logic [15:0] A = 16'h0000;
  logic        CONFIGURED = 1'b0;
  logic        BRIDGE_VALID = 1'b0, LIDE_VALID = 1'b0, PRO_VALID = 1'b0;
  logic [7:0]  BRIDGE_BASE = 8'h00;
  logic [6:0]  LIDE_BASE = 7'h00;
  logic [2:0]  PRO_BASE = 3'b000;
  logic        AC_TACK = 1'b0, BRIDGE_ACK = 1'b0, LIDE_ACK = 1'b0, PRO_ACK = 1'b0;
  logic        AUTOCONFIG_SPACE, SEL_BRIDGE, SEL_LIDE, SEL_PRO;
  logic        CYC_RnW, CYC_ACTIVE, TACK_OUT, TEA_OUT;
  logic [6:0]  outs;

  int tests = 0;
  int fails = 0;

  u409_target_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .CLK40(CLK40), .RESETn(RESETn), .TSn(TSn), .RnW(RnW), .A(A),
    .CONFIGURED(CONFIGURED), .BRIDGE_VALID(BRIDGE_VALID),
    .LIDE_VALID(LIDE_VALID), .PRO_VALID(PRO_VALID),
    .BRIDGE_BASE(BRIDGE_BASE), .LIDE_BASE(LIDE_BASE), .PRO_BASE(PRO_BASE),
    .AC_TACK(AC_TACK), .BRIDGE_ACK(BRIDGE_ACK), .LIDE_ACK(LIDE_ACK),
    .PRO_ACK(PRO_ACK), .AUTOCONFIG_SPACE(AUTOCONFIG_SPACE),
    .SEL_BRIDGE(SEL_BRIDGE), .SEL_LIDE(SEL_LIDE), .SEL_PRO(SEL_PRO),
    .CYC_RnW(CYC_RnW), .CYC_ACTIVE(CYC_ACTIVE), .TACK_OUT(TACK_OUT),
    .TEA_OUT(TEA_OUT)
  );

  always #5 CLK40 = ~CLK40;

  assign outs = {AUTOCONFIG_SPACE, SEL_BRIDGE, SEL_LIDE, SEL_PRO,
                 CYC_ACTIVE, TACK_OUT, TEA_OUT};

  // Advance one rising edge and settle.
  task automatic tick;
    @(posedge CLK40);
    #1;
  endtask

  // Drive TSn low across one edge (edge N), release it afterwards.
  task automatic start_cycle(input logic [15:0] addr, input logic rnw);
    A = addr; RnW = rnw; TSn = 1'b0;
    tick;
    TSn = 1'b1;
  endtask

  task automatic test_reset;
    #1 RESETn = 1'b0;
    #1;
    tests++;
    if (outs !== 7'b0 || CYC_RnW !== 1'b0) begin
      fails++; $display("FAIL reset_state: got outs=%b rnw=%b want 0000000/0", outs, CYC_RnW);
    end
    tick; tick;
    RESETn = 1'b1;
    tick;
    tests++;
    if (outs !== 7'b0) begin
      fails++; $display("FAIL reset_release: got %b want 0000000", outs);
    end
  endtask

  task automatic test_autoconfig;
    CONFIGURED = 1'b0;
    start_cycle(16'h00E8, 1'b1);
    tests++;
    if (outs !== 7'b0) begin fails++; $display("FAIL ac_decode_n: got %b want 0000000", outs); end
    tick; // N+1
    tests++;
    if (outs !== 7'b1000100) begin fails++; $display("FAIL ac_sel_n1: got %b want 1000100", outs); end
    tick; // N+2 still waiting
    tests++;
    if (outs !== 7'b1000100) begin fails++; $display("FAIL ac_wait_n2: got %b want 1000100", outs); end
    AC_TACK = 1'b1;
    tick; // N+3 TERM
    AC_TACK = 1'b0;
    tests++;
    if (outs !== 7'b1000100) begin fails++; $display("FAIL ac_term_n3: got %b want 1000100", outs); end
    tick; // N+4
    tests++;
    if (outs !== 7'b0000010) begin fails++; $display("FAIL ac_tack: got %b want 0000010", outs); end
    tick;
    tests++;
    if (outs !== 7'b0) begin fails++; $display("FAIL ac_tack_single: got %b want 0000000", outs); end
  endtask

  task automatic test_bridge;
    CONFIGURED = 1'b1; BRIDGE_VALID = 1'b1; BRIDGE_BASE = 8'hE9;
    start_cycle(16'h00E9, 1'b1);
    tests++;
    if (CYC_RnW !== 1'b1) begin fails++; $display("FAIL br_rnw: got %b want 1", CYC_RnW); end
    tick; // N+1
    tests++;
    if (outs !== 7'b0100100) begin fails++; $display("FAIL br_sel: got %b want 0100100", outs); end
    BRIDGE_ACK = 1'b1;
    BRIDGE_BASE = 8'h00; // must not disturb the latched decode
    tick; // N+2
    BRIDGE_ACK = 1'b0;
    tests++;
    if (outs !== 7'b0100100) begin fails++; $display("FAIL br_term: got %b want 0100100", outs); end
    tick; // N+3
    tests++;
    if (outs !== 7'b0000010) begin fails++; $display("FAIL br_tack_n3: got %b want 0000010", outs); end
    BRIDGE_BASE = 8'hE9;
    tick;
  endtask

  task automatic test_lide_ack_filter;
    LIDE_VALID = 1'b1; LIDE_BASE = 7'h75;
    start_cycle(16'h00EB, 1'b0);
    tests++;
    if (CYC_RnW !== 1'b0) begin fails++; $display("FAIL lide_rnw: got %b want 0", CYC_RnW); end
    tick;
    tests++;
    if (outs !== 7'b0010100) begin fails++; $display("FAIL lide_sel: got %b want 0010100", outs); end
    BRIDGE_ACK = 1'b1;
    tick; tick;
    tests++;
    if (outs !== 7'b0010100) begin fails++; $display("FAIL lide_foreign_ack: got %b want 0010100", outs); end
    LIDE_ACK = 1'b1;
    tick;
    LIDE_ACK = 1'b0; BRIDGE_ACK = 1'b0;
    tick;
    tests++;
    if (outs !== 7'b0000010) begin fails++; $display("FAIL lide_tack: got %b want 0000010", outs); end
    tick;
  endtask

  task automatic test_pro_and_miss;
    PRO_VALID = 1'b1; PRO_BASE = 3'b010;
    start_cycle(16'h4123, 1'b1);
    tick;
    tests++;
    if (outs !== 7'b0001100) begin fails++; $display("FAIL pro_sel: got %b want 0001100", outs); end
    PRO_ACK = 1'b1;
    tick;
    PRO_ACK = 1'b0;
    tick;
    tests++;
    if (outs !== 7'b0000010) begin fails++; $display("FAIL pro_tack: got %b want 0000010", outs); end
    tick;
    // A28 set: not ours, back to IDLE right after DECODE
    start_cycle(16'h5123, 1'b1);
    tick;
    tests++;
    if (outs[6:3] !== 4'b0 || TACK_OUT !== 1'b0) begin
      fails++; $display("FAIL pro_miss: got %b want no select/no tack", outs);
    end
    start_cycle(16'h4123, 1'b1);
    tick;
    tests++;
    if (outs !== 7'b0001100) begin fails++; $display("FAIL miss_then_hit: got %b want 0001100", outs); end
    PRO_ACK = 1'b1;
    tick;
    PRO_ACK = 1'b0;
    tick; tick;
  endtask

  task automatic test_timeout;
    start_cycle(16'h4123, 1'b1);
    tick; // N+1, WAIT cycle 1 begins
    repeat (7) tick; // edges N+2..N+8
    tests++;
    if (outs !== 7'b0001100) begin fails++; $display("FAIL to_wait7: got %b want 0001100", outs); end
`ifdef U409_BUS_TIMEOUT_EN
    tick; // N+9 -> ERR
    tick; // N+10
    tests++;
    if (outs !== 7'b0000001) begin fails++; $display("FAIL to_tea: got %b want 0000001", outs); end
    tick;
    tests++;
    if (outs !== 7'b0) begin fails++; $display("FAIL to_tea_single: got %b want 0000000", outs); end
`else
    repeat (20) tick;
    tests++;
    if (outs !== 7'b0001100) begin fails++; $display("FAIL to_nowd_wait: got %b want 0001100", outs); end
    PRO_ACK = 1'b1;
    tick;
    PRO_ACK = 1'b0;
    tick;
    tests++;
    if (outs !== 7'b0000010) begin fails++; $display("FAIL to_nowd_tack: got %b want 0000010", outs); end
    tick;
`endif
    // ack in the 8th wait cycle beats the timeout
    start_cycle(16'h4123, 1'b1);
    tick;
    repeat (7) tick;
    PRO_ACK = 1'b1;
    tick; // N+9 -> TERM
    PRO_ACK = 1'b0;
    tick; // N+10
    tests++;
    if (outs !== 7'b0000010) begin fails++; $display("FAIL to_ack_wins: got %b want 0000010", outs); end
    tick;
  endtask

  task automatic test_back_to_back;
    start_cycle(16'h00E9, 1'b1);
    tick;
    BRIDGE_ACK = 1'b1;
    tick;
    BRIDGE_ACK = 1'b0;
    tick; // N+3: TACK, FSM idle
    tests++;
    if (outs !== 7'b0000010) begin fails++; $display("FAIL b2b_tack1: got %b want 0000010", outs); end
    start_cycle(16'h00EB, 1'b0); // latched at N+4
    tests++;
    if (outs !== 7'b0) begin fails++; $display("FAIL b2b_gap: got %b want 0000000", outs); end
    tick;
    tests++;
    if (outs !== 7'b0010100) begin fails++; $display("FAIL b2b_sel2: got %b want 0010100", outs); end
    LIDE_ACK = 1'b1;
    tick;
    LIDE_ACK = 1'b0;
    tick;
    tests++;
    if (outs !== 7'b0000010) begin fails++; $display("FAIL b2b_tack2: got %b want 0000010", outs); end
    tick;
  endtask

  task automatic test_reset_mid;
    start_cycle(16'h00E9, 1'b1);
    tick; // WAIT_ACK
    #2 RESETn = 1'b0;
    #1;
    tests++;
    if (outs !== 7'b0 || CYC_RnW !== 1'b0) begin
      fails++; $display("FAIL rst_mid_async: got outs=%b rnw=%b want 0000000/0", outs, CYC_RnW);
    end
    BRIDGE_ACK = 1'b1;
    tick;
    BRIDGE_ACK = 1'b0;
    RESETn = 1'b1;
    tick; tick; tick;
    tests++;
    if (outs !== 7'b0) begin fails++; $display("FAIL rst_mid_stale: got %b want 0000000", outs); end
    start_cycle(16'h00E9, 1'b1);
    tick;
    tests++;
    if (outs !== 7'b0100100) begin fails++; $display("FAIL rst_mid_redecode: got %b want 0100100", outs); end
    BRIDGE_ACK = 1'b1;
    tick;
    BRIDGE_ACK = 1'b0;
    tick;
    tests++;
    if (outs !== 7'b0000010) begin fails++; $display("FAIL rst_mid_tack: got %b want 0000010", outs); end
    tick;
  endtask

  initial begin
    test_reset;
    test_autoconfig;
    test_bridge;
    test_lide_ack_filter;
    test_pro_and_miss;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
